fu_result_buffer: RTL and testbench

Holds completed functional-unit results, one single-entry slot per FU, until the FU selector grants one per cycle onto the CDB. Sits directly upstream of `fu_selector`: it drives `fu_result_valid`, consumes the returned `fu_num`/`cat_select` grant, and registers the granted result onto the CDB. It also back-pressures FUs whose result is waiting and clears all held results on squash.

---
 rtl/sys_defs.sv | 45 ++++
 rtl/fu_result_slot.sv | 73 +++++++
 rtl/fu_result_buffer.sv | 96 +++++++++
 tb/tb_fu_result_buffer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/sys_defs.sv
// -----------------------------------------------------------------------------
// sys_defs: shared FU constants, result record and slot state for the FU result
// buffer.
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package sys_defs;

    localparam int NUM_ALU     = 8;
    localparam int NUM_LS      = 4;
    localparam int NUM_MULT    = 4;
    localparam int NUM_BEQ     = 4;
    localparam int ALU_OFFSET  = 0;
    localparam int LS_OFFSET   = ALU_OFFSET + NUM_ALU;
    localparam int MULT_OFFSET = LS_OFFSET + NUM_LS;
    localparam int BEQ_OFFSET  = MULT_OFFSET + NUM_MULT;
    localparam int FU_SIZE     = BEQ_OFFSET + NUM_BEQ;
    localparam int FU_CAT      = 4;
    localparam int XLEN        = 32;
    localparam int TAG_W       = 6;
    localparam int FU_NUM_W    = $clog2(FU_SIZE) + 1;

    typedef struct packed {
        logic [XLEN-1:0]  value;
        logic [TAG_W-1:0] tag;
    } fu_result_t;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

    function automatic logic [FU_NUM_W-1:0] popcount(input logic [FU_SIZE-1:0] v);
        logic [FU_NUM_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < FU_SIZE; i++) begin
            cnt = cnt + FU_NUM_W'(v[i]);
        end
        return cnt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fu_result_slot.sv
// -----------------------------------------------------------------------------
// fu_result_slot: single-entry holding register for one FU result, with
// capture, drain, back-to-back refill and squash.
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module fu_result_slot
    import sys_defs::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       i_squash,
    input  logic       i_done,
    input  logic       i_drain,
    input  fu_result_t i_result,
    output logic       o_full,
    output logic       o_full_nxt,
    output logic       o_stall,
    output fu_result_t o_result
);

    slot_state_e r_state;
    slot_state_e w_state_nxt;
    fu_result_t  r_result;
    fu_result_t  w_result_nxt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= EMPTY;
            r_result <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_result <= w_result_nxt;
        end
    end

    // A FULL slot that is not drained ignores i_done: its FU is stalled.
    always_comb begin
        w_state_nxt  = r_state;
        w_result_nxt = r_result;
        if (i_squash) begin
            w_state_nxt = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (i_done) begin
                        w_state_nxt  = FULL;
                        w_result_nxt = i_result;
                    end
                end
                FULL: begin
                    if (i_drain) begin
                        if (i_done) begin
                            w_result_nxt = i_result;
                        end else begin
                            w_state_nxt = EMPTY;
                        end
                    end
                end
                default: w_state_nxt = EMPTY;
            endcase
        end
    end

    assign o_full     = (r_state == FULL);
    assign o_full_nxt = (w_state_nxt == FULL);
    assign o_stall    = o_full && !i_drain;
    assign o_result   = r_result;

endmodule

`default_nettype wire

// File: rtl/fu_result_buffer.sv
// -----------------------------------------------------------------------------
// fu_result_buffer: per-FU result slots, grant decode from the FU selector,
// registered CDB broadcast and occupancy count.
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module fu_result_buffer
    import sys_defs::*;
(
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     squash,
    input  logic [FU_SIZE-1:0]       fu_done,
    input  logic [FU_SIZE*XLEN-1:0]  fu_value,
    input  logic [FU_SIZE*TAG_W-1:0] fu_tag,
    output logic [FU_SIZE-1:0]       fu_stall,
    output logic [FU_SIZE-1:0]       fu_result_valid,
    input  logic [FU_NUM_W-1:0]      fu_num,
    input  logic [FU_CAT-1:0]        cat_select,
    output logic                     cdb_valid,
    output logic [XLEN-1:0]          cdb_value,
    output logic [TAG_W-1:0]         cdb_tag,
    output logic [FU_NUM_W-1:0]      busy_count
);

    logic               w_grant_valid;
    logic [FU_SIZE-1:0] w_drain;
    logic [FU_SIZE-1:0] w_full;
    logic [FU_SIZE-1:0] w_full_nxt;
    fu_result_t         w_slot_res [FU_SIZE];
    logic [XLEN-1:0]    w_sel_value;
    logic [TAG_W-1:0]   w_sel_tag;
    logic               w_any_drain;

    // fu_num==0 alone is indistinguishable from "no selection"; cat_select qualifies it.
    assign w_grant_valid = |cat_select;

    generate
        for (genvar i = 0; i < FU_SIZE; i++) begin : g_slot
            fu_result_t w_in;
            assign w_in.value = fu_value[i*XLEN +: XLEN];
            assign w_in.tag   = fu_tag[i*TAG_W +: TAG_W];
            assign w_drain[i] = w_grant_valid && (fu_num == FU_NUM_W'(i)) && w_full[i];

            fu_result_slot u_slot (
                .clock      (clock),
                .reset      (reset),
                .i_squash   (squash),
                .i_done     (fu_done[i]),
                .i_drain    (w_drain[i]),
                .i_result   (w_in),
                .o_full     (w_full[i]),
                .o_full_nxt (w_full_nxt[i]),
                .o_stall    (fu_stall[i]),
                .o_result   (w_slot_res[i])
            );
        end
    endgenerate

    assign fu_result_valid = w_full;
    assign w_any_drain     = |w_drain;

    // w_drain is at most one-hot, so an AND-OR mux suffices.
    always_comb begin
        w_sel_value = '0;
        w_sel_tag   = '0;
        for (int i = 0; i < FU_SIZE; i++) begin
            if (w_drain[i]) begin
                w_sel_value = w_sel_value | w_slot_res[i].value;
                w_sel_tag   = w_sel_tag | w_slot_res[i].tag;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cdb_valid  <= 1'b0;
            cdb_value  <= '0;
            cdb_tag    <= '0;
            busy_count <= '0;
        end else begin
            busy_count <= popcount(w_full_nxt);
            if (!squash && w_any_drain) begin
                cdb_valid <= 1'b1;
                cdb_value <= w_sel_value;
                cdb_tag   <= w_sel_tag;
            end else begin
                cdb_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fu_result_buffer.sv
// -----------------------------------------------------------------------------
// tb_fu_result_buffer: table-driven directed bench for fu_result_buffer; slot i
// receives value (v ^ i) and tag (t ^ i) from each vector.
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_fu_result_buffer;
    import sys_defs::*;

    logic                     clock;
    logic                     reset;
    logic                     squash;
    logic [FU_SIZE-1:0]       fu_done;
    logic [FU_SIZE*XLEN-1:0]  fu_value;
    logic [FU_SIZE*TAG_W-1:0] fu_tag;
    logic [FU_SIZE-1:0]       fu_stall;
    logic [FU_SIZE-1:0]       fu_result_valid;
    logic [FU_NUM_W-1:0]      fu_num;
    logic [FU_CAT-1:0]        cat_select;
    logic                     cdb_valid;
    logic [XLEN-1:0]          cdb_value;
    logic [TAG_W-1:0]         cdb_tag;
    logic [FU_NUM_W-1:0]      busy_count;

    int n_checks = 0;
    int n_fails  = 0;

    fu_result_buffer dut (
        .clock           (clock),
        .reset           (reset),
        .squash          (squash),
        .fu_done         (fu_done),
        .fu_value        (fu_value),
        .fu_tag          (fu_tag),
        .fu_stall        (fu_stall),
        .fu_result_valid (fu_result_valid),
        .fu_num          (fu_num),
        .cat_select      (cat_select),
        .cdb_valid       (cdb_valid),
        .cdb_value       (cdb_value),
        .cdb_tag         (cdb_tag),
        .busy_count      (busy_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic               sq;
        logic [FU_SIZE-1:0] done;
        logic [XLEN-1:0]    v;
        logic [TAG_W-1:0]   t;
        logic [FU_NUM_W-1:0] num;
        logic [FU_CAT-1:0]  cat;
        logic [FU_SIZE-1:0] e_stall;
        logic [FU_SIZE-1:0] e_valid;
        logic               e_cv;
        logic [XLEN-1:0]    e_val;
        logic [TAG_W-1:0]   e_tag;
        logic [FU_NUM_W-1:0] e_busy;
    } vec_t;

    vec_t vecs [19];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic sq, input logic [FU_SIZE-1:0] done, input logic [XLEN-1:0] v,
                         input logic [TAG_W-1:0] t, input logic [FU_NUM_W-1:0] num,
                         input logic [FU_CAT-1:0] cat);
        squash     = sq;
        fu_done    = done;
        fu_num     = num;
        cat_select = cat;
        for (int i = 0; i < FU_SIZE; i++) begin
            fu_value[i*XLEN +: XLEN]   = v ^ XLEN'(i);
            fu_tag[i*TAG_W +: TAG_W]   = t ^ TAG_W'(i);
        end
    endtask

    function automatic vec_t mk(input logic sq, input logic [FU_SIZE-1:0] done, input logic [XLEN-1:0] v,
                                input logic [TAG_W-1:0] t, input logic [FU_NUM_W-1:0] num,
                                input logic [FU_CAT-1:0] cat, input logic [FU_SIZE-1:0] e_stall,
                                input logic [FU_SIZE-1:0] e_valid, input logic e_cv,
                                input logic [XLEN-1:0] e_val, input logic [TAG_W-1:0] e_tag,
                                input logic [FU_NUM_W-1:0] e_busy);
        vec_t r;
        r.sq = sq; r.done = done; r.v = v; r.t = t; r.num = num; r.cat = cat;
        r.e_stall = e_stall; r.e_valid = e_valid; r.e_cv = e_cv;
        r.e_val = e_val; r.e_tag = e_tag; r.e_busy = e_busy;
        return r;
    endfunction

    initial begin
        // single result to slot 3, then grant
        vecs[0]  = mk(0, 20'h00008, 32'hDEADBEEC, 6'd4, 6'd0, 4'b0000, 20'h0,     20'h00008, 0, 32'h0,        6'd0,  6'd1);
        vecs[1]  = mk(0, 20'h00000, 32'h0,        6'd0, 6'd3, 4'b0001, 20'h0,     20'h00000, 1, 32'hDEADBEEF, 6'd7,  6'd0);
        // contention between slots 2 and 9
        vecs[2]  = mk(0, 20'h00204, 32'h100,      6'd0, 6'd0, 4'b0000, 20'h0,     20'h00204, 0, 32'hDEADBEEF, 6'd7,  6'd2);
        vecs[3]  = mk(0, 20'h00004, 32'h200,      6'd0, 6'd9, 4'b0010, 20'h00004, 20'h00004, 1, 32'h109,      6'd9,  6'd1);
        vecs[4]  = mk(0, 20'h00000, 32'h0,        6'd0, 6'd0, 4'b0000, 20'h00004, 20'h00004, 0, 32'h109,      6'd9,  6'd1);
        vecs[5]  = mk(0, 20'h00000, 32'h0,        6'd0, 6'd2, 4'b0001, 20'h0,     20'h00000, 1, 32'h102,      6'd2,  6'd0);
        // back-to-back on slot 0
        vecs[6]  = mk(0, 20'h00001, 32'h1,        6'd1, 6'd0, 4'b0000, 20'h0,     20'h00001, 0, 32'h102,      6'd2,  6'd1);
        vecs[7]  = mk(0, 20'h00001, 32'h2,        6'd2, 6'd0, 4'b0001, 20'h0,     20'h00001, 1, 32'h1,        6'd1,  6'd1);
        vecs[8]  = mk(0, 20'h00001, 32'h3,        6'd3, 6'd0, 4'b0001, 20'h0,     20'h00001, 1, 32'h2,        6'd2,  6'd1);
        vecs[9]  = mk(0, 20'h00000, 32'h0,        6'd0, 6'd0, 4'b0001, 20'h0,     20'h00000, 1, 32'h3,        6'd3,  6'd0);
        // bogus grants against a full slot 0
        vecs[10] = mk(0, 20'h00001, 32'h50,       6'd5, 6'd0, 4'b0000, 20'h0,     20'h00001, 0, 32'h3,        6'd3,  6'd1);
        vecs[11] = mk(0, 20'h00000, 32'h0,        6'd0, 6'd0, 4'b0000, 20'h00001, 20'h00001, 0, 32'h3,        6'd3,  6'd1);
        vecs[12] = mk(0, 20'h00000, 32'h0,        6'd0, 6'd20, 4'b1000, 20'h00001, 20'h00001, 0, 32'h3,       6'd3,  6'd1);
        vecs[13] = mk(0, 20'h00000, 32'h0,        6'd0, 6'd7, 4'b0001, 20'h00001, 20'h00001, 0, 32'h3,        6'd3,  6'd1);
        // squash with slots 0,1,4,12 full, a done and a grant in the same cycle
        vecs[14] = mk(0, 20'h01012, 32'h1000,     6'h10, 6'd0, 4'b0000, 20'h00001, 20'h01013, 0, 32'h3,       6'd3,  6'd4);
        vecs[15] = mk(1, 20'h00040, 32'h0,        6'd0, 6'd4, 4'b0100, 20'h01003, 20'h00000, 0, 32'h3,        6'd3,  6'd0);
        // all slots full
        vecs[16] = mk(0, 20'hFFFFF, 32'h0,        6'd0, 6'd0, 4'b0000, 20'h0,     20'hFFFFF, 0, 32'h3,        6'd3,  6'd20);
        vecs[17] = mk(0, 20'h00000, 32'h0,        6'd0, 6'd0, 4'b0000, 20'hFFFFF, 20'hFFFFF, 0, 32'h3,        6'd3,  6'd20);
        vecs[18] = mk(0, 20'h00000, 32'h0,        6'd0, 6'd19, 4'b1000, 20'h7FFFF, 20'h7FFFF, 1, 32'h13,      6'h13, 6'd19);

        reset = 1'b1;
        drive(0, '0, '0, '0, '0, '0);
        @(negedge clock);
        @(negedge clock);
        #1;
        chk("reset_valid", 64'(fu_result_valid), 64'h0);
        chk("reset_stall", 64'(fu_stall), 64'h0);
        chk("reset_cdb_valid", 64'(cdb_valid), 64'h0);
        chk("reset_cdb_value", 64'(cdb_value), 64'h0);
        chk("reset_cdb_tag", 64'(cdb_tag), 64'h0);
        chk("reset_busy", 64'(busy_count), 64'h0);
        @(negedge clock);
        reset = 1'b0;

        for (int k = 0; k < 19; k++) begin
            @(negedge clock);
            drive(vecs[k].sq, vecs[k].done, vecs[k].v, vecs[k].t, vecs[k].num, vecs[k].cat);
            #1;
            chk($sformatf("v%0d_stall", k), 64'(fu_stall), 64'(vecs[k].e_stall));
            @(posedge clock);
            #1;
            chk($sformatf("v%0d_valid", k), 64'(fu_result_valid), 64'(vecs[k].e_valid));
            chk($sformatf("v%0d_cdb_valid", k), 64'(cdb_valid), 64'(vecs[k].e_cv));
            chk($sformatf("v%0d_cdb_value", k), 64'(cdb_value), 64'(vecs[k].e_val));
            chk($sformatf("v%0d_cdb_tag", k), 64'(cdb_tag), 64'(vecs[k].e_tag));
            chk($sformatf("v%0d_busy", k), 64'(busy_count), 64'(vecs[k].e_busy));
        end

        // reset mid-operation: refill slots 0, 5, 19 then reset between edges
        @(negedge clock);
        drive(1, '0, '0, '0, '0, '0);
        @(negedge clock);
        drive(0, 20'h80021, 32'hA0, 6'd0, 6'd0, 4'b0000);
        @(posedge clock);
        #1;
        chk("mid_fill_valid", 64'(fu_result_valid), 64'h80021);
        chk("mid_fill_busy", 64'(busy_count), 64'd3);
        drive(0, '0, '0, '0, 6'd5, 4'b0010);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_reset_valid", 64'(fu_result_valid), 64'h0);
        chk("mid_reset_cdb_valid", 64'(cdb_valid), 64'h0);
        chk("mid_reset_stall", 64'(fu_stall), 64'h0);
        chk("mid_reset_busy", 64'(busy_count), 64'h0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk("post_reset_cdb_valid", 64'(cdb_valid), 64'h0);
        chk("post_reset_valid", 64'(fu_result_valid), 64'h0);
        chk("post_reset_cdb_value", 64'(cdb_value), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
